fp_mul_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined IEEE-754 multiplier for the FPU datapath; successor to the combinational multiplier.

---
 rtl/fpu_pkg.sv | 58 +++++
 rtl/fpmul_norm_round.sv | 113 +++++++++++
 rtl/fp_mul_pipe.sv | 174 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types: formats, rounding modes, operand classes, flag bits.
// Subnormal support in the multiplier is selected by the FPMUL_DENORM_EN macro.
`timescale 1ns/1ps
package fpu_pkg;

    localparam int FPU_EXP_W = 8;
    localparam int FPU_MAN_W = 23;
    localparam int FPU_FP_W  = 1 + FPU_EXP_W + FPU_MAN_W;
    localparam int FPU_BIAS  = (1 << (FPU_EXP_W - 1)) - 1;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rm_e;

    typedef enum logic [2:0] {
        FC_ZERO,
        FC_SUB,
        FC_NORM,
        FC_INF,
        FC_QNAN,
        FC_SNAN
    } fp_class_e;

    typedef struct packed {
        logic                 sign;
        logic [FPU_EXP_W-1:0] exp;
        logic [FPU_MAN_W:0]   mant;
        fp_class_e            cls;
    } fp_unpacked_t;

    // Subnormals collapse to zero when the datapath runs flush-to-zero.
    function automatic fp_class_e fp_classify(
        input logic e_ones,
        input logic e_zero,
        input logic f_zero,
        input logic f_msb,
        input logic denorm
    );
        fp_class_e c;
        if (e_ones)
            c = f_zero ? FC_INF : (f_msb ? FC_QNAN : FC_SNAN);
        else if (e_zero)
            c = (f_zero || !denorm) ? FC_ZERO : FC_SUB;
        else
            c = FC_NORM;
        return c;
    endfunction

endpackage

// File: rtl/fpmul_norm_round.sv
// Normalise, round, pack and flag a raw significand product.
// DENORM=1 gives gradual underflow, DENORM=0 flushes tiny results.
`timescale 1ns/1ps
module fpmul_norm_round
    import fpu_pkg::*;
#(
    parameter int EXP_W  = FPU_EXP_W,
    parameter int MAN_W  = FPU_MAN_W,
    parameter bit DENORM = 1'b0
) (
    input  logic                     sign,
    input  logic [EXP_W+1:0]         exp_in,
    input  logic [2*(MAN_W+1)-1:0]   prod,
    input  rm_e                      rm,
    output logic [EXP_W+MAN_W:0]     res,
    output logic [4:0]               flags
);

    localparam int PW     = 2 * (MAN_W + 1);
    localparam int XW     = EXP_W + 2;
    localparam int SW     = $clog2(PW + 1);
    localparam int E_ONES = (1 << EXP_W) - 1;

    logic [SW-1:0]      lz;
    logic [PW-1:0]      norm;
    logic [XW-1:0]      e_norm;
    logic               tiny;
    logic [XW-1:0]      sh_amt;
    logic [XW-1:0]      rsh;
    logic [2*PW-1:0]    wide;
    logic [MAN_W:0]     keep;
    logic               guard;
    logic               sticky;
    logic               inexact;
    logic               inc;
    logic [MAN_W+1:0]   mant_r;
    logic [XW-1:0]      e_fin;
    logic [MAN_W-1:0]   frac;
    logic               ovf;

    always_comb begin
        lz = SW'(PW);
        for (int i = 0; i < PW; i++) begin
            if (prod[i]) lz = SW'(PW - 1 - i);
        end
    end

    // Leading one lands on the MSB; a product in [2,4) bumps the exponent.
    assign norm   = prod << lz;
    assign e_norm = exp_in + XW'(1) - XW'(lz);
    assign tiny   = e_norm[XW-1] | (e_norm == '0);
    assign sh_amt = XW'(1) - e_norm;

    always_comb begin
        rsh = '0;
        if (DENORM && tiny)
            rsh = (sh_amt > XW'(PW)) ? XW'(PW) : sh_amt;
    end

    assign wide    = {norm, {PW{1'b0}}} >> rsh;
    assign keep    = wide[2*PW-1 -: MAN_W+1];
    assign guard   = wide[2*PW-MAN_W-2];
    assign sticky  = |wide[2*PW-MAN_W-3:0];
    assign inexact = guard | sticky;

    always_comb begin
        case (rm)
            RM_RNE:  inc = guard & (sticky | keep[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & inexact;
            default: inc = ~sign & inexact;
        endcase
    end

    assign mant_r = {1'b0, keep} + {{(MAN_W+1){1'b0}}, inc};

    always_comb begin
        e_fin = e_norm;
        frac  = mant_r[MAN_W-1:0];
        if (mant_r[MAN_W+1]) begin
            e_fin = e_norm + XW'(1);
            frac  = mant_r[MAN_W:1];
        end else if (tiny) begin
            e_fin = {{(XW-1){1'b0}}, mant_r[MAN_W]};
        end
        ovf = !tiny && (e_fin >= XW'(E_ONES));
    end

    always_comb begin
        res   = {sign, e_fin[EXP_W-1:0], frac};
        flags = '0;
        flags[FLG_NX] = inexact;
        if (tiny) begin
            if (DENORM) begin
                flags[FLG_UF] = inexact;
            end else begin
                res           = {sign, {(EXP_W+MAN_W){1'b0}}};
                flags[FLG_UF] = 1'b1;
                flags[FLG_NX] = 1'b1;
            end
        end else if (ovf) begin
            flags[FLG_OF] = 1'b1;
            flags[FLG_NX] = 1'b1;
            res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            if ((rm == RM_RTZ) ||
                (rm == RM_RDN && !sign) ||
                (rm == RM_RUP && sign))
                res = {sign, {(EXP_W-1){1'b1}}, 1'b0,
                       {MAN_W{1'b1}}};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready flow control.
// Define FPMUL_DENORM_EN for gradual underflow; default is flush-to-zero.
`timescale 1ns/1ps
module fp_mul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = FPU_EXP_W,
    parameter int MAN_W = FPU_MAN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+MAN_W:0]  in_a,
    input  logic [EXP_W+MAN_W:0]  in_b,
    input  logic [1:0]            in_rm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+MAN_W:0]  out_res,
    output logic [4:0]            out_flags
);

    localparam int FP_W = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int XW   = EXP_W + 2;
    localparam int PW   = 2 * (MAN_W + 1);

`ifdef FPMUL_DENORM_EN
    localparam bit DENORM = 1'b1;
`else
    localparam bit DENORM = 1'b0;
`endif

    localparam logic [FP_W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic             a_s, b_s;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_f, b_f;
    fp_class_e        a_c, b_c;
    logic [EXP_W-1:0] a_x, b_x;
    logic             sgn;
    logic [XW-1:0]    exp_sum;

    assign {a_s, a_e, a_f} = in_a;
    assign {b_s, b_e, b_f} = in_b;
    assign a_c = fp_classify(&a_e, ~|a_e, ~|a_f, a_f[MAN_W-1], DENORM);
    assign b_c = fp_classify(&b_e, ~|b_e, ~|b_f, b_f[MAN_W-1], DENORM);

    // Subnormals use an effective exponent of 1.
    assign a_x     = a_e | {{(EXP_W-1){1'b0}}, ~|a_e};
    assign b_x     = b_e | {{(EXP_W-1){1'b0}}, ~|b_e};
    assign sgn     = a_s ^ b_s;
    assign exp_sum = {2'b00, a_x} + {2'b00, b_x} - XW'(BIAS);

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic is_nan, is_inv, is_inf, is_zero;
    logic             sp_hit;
    logic [FP_W-1:0]  sp_res;
    logic [4:0]       sp_flags;

    assign a_nan  = (a_c == FC_QNAN) || (a_c == FC_SNAN);
    assign b_nan  = (b_c == FC_QNAN) || (b_c == FC_SNAN);
    assign a_inf  = (a_c == FC_INF);
    assign b_inf  = (b_c == FC_INF);
    assign a_zero = (a_c == FC_ZERO);
    assign b_zero = (b_c == FC_ZERO);

    assign is_nan  = a_nan | b_nan;
    assign is_inv  = !is_nan && ((a_inf && b_zero) || (a_zero && b_inf));
    assign is_inf  = !is_nan && !is_inv && (a_inf || b_inf);
    assign is_zero = !is_nan && !a_inf && !b_inf && (a_zero || b_zero);

    always_comb begin
        sp_hit   = 1'b1;
        sp_res   = '0;
        sp_flags = '0;
        unique case (1'b1)
            is_nan: begin
                sp_res = QNAN;
                sp_flags[FLG_NV] = (a_c == FC_SNAN) || (b_c == FC_SNAN);
            end
            is_inv: begin
                sp_res = QNAN;
                sp_flags[FLG_NV] = 1'b1;
            end
            is_inf:  sp_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            is_zero: sp_res = {sgn, {(EXP_W+MAN_W){1'b0}}};
            default: sp_hit = 1'b0;
        endcase
    end

    logic             s1_v, s1_sign, s1_sp;
    logic [XW-1:0]    s1_exp;
    logic [MAN_W:0]   s1_ma, s1_mb;
    logic [FP_W-1:0]  s1_sp_res;
    logic [4:0]       s1_sp_flags;
    rm_e              s1_rm;

    logic             s2_v, s2_sign, s2_sp;
    logic [XW-1:0]    s2_exp;
    logic [PW-1:0]    s2_prod;
    logic [FP_W-1:0]  s2_sp_res;
    logic [4:0]       s2_sp_flags;
    rm_e              s2_rm;

    logic [FP_W-1:0]  nr_res;
    logic [4:0]       nr_flags;

    fpmul_norm_round #(
        .EXP_W  (EXP_W),
        .MAN_W  (MAN_W),
        .DENORM (DENORM)
    ) u_norm_round (
        .sign   (s2_sign),
        .exp_in (s2_exp),
        .prod   (s2_prod),
        .rm     (s2_rm),
        .res    (nr_res),
        .flags  (nr_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v        <= 1'b0;
            s1_sign     <= 1'b0;
            s1_sp       <= 1'b0;
            s1_exp      <= '0;
            s1_ma       <= '0;
            s1_mb       <= '0;
            s1_sp_res   <= '0;
            s1_sp_flags <= '0;
            s1_rm       <= RM_RNE;
            s2_v        <= 1'b0;
            s2_sign     <= 1'b0;
            s2_sp       <= 1'b0;
            s2_exp      <= '0;
            s2_prod     <= '0;
            s2_sp_res   <= '0;
            s2_sp_flags <= '0;
            s2_rm       <= RM_RNE;
            out_valid   <= 1'b0;
            out_res     <= '0;
            out_flags   <= '0;
        end else if (adv) begin
            s1_v        <= in_valid;
            s1_sign     <= sgn;
            s1_sp       <= sp_hit;
            s1_exp      <= exp_sum;
            s1_ma       <= {a_c == FC_NORM, a_f};
            s1_mb       <= {b_c == FC_NORM, b_f};
            s1_sp_res   <= sp_res;
            s1_sp_flags <= sp_flags;
            s1_rm       <= rm_e'(in_rm);
            s2_v        <= s1_v;
            s2_sign     <= s1_sign;
            s2_sp       <= s1_sp;
            s2_exp      <= s1_exp;
            s2_prod     <= PW'(s1_ma) * PW'(s1_mb);
            s2_sp_res   <= s1_sp_res;
            s2_sp_flags <= s1_sp_flags;
            s2_rm       <= s1_rm;
            out_valid   <= s2_v;
            out_res     <= s2_sp ? s2_sp_res : nr_res;
            out_flags   <= s2_sp ? s2_sp_flags : nr_flags;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: directed vectors, stall and reset.
`timescale 1ns/1ps
module tb_fp_mul_pipe;

    localparam logic [4:0] NX = 5'b00001;
    localparam logic [4:0] UF = 5'b00010;
    localparam logic [4:0] OF = 5'b00100;
    localparam logic [4:0] NV = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [1:0]  in_rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_res;
    logic [4:0]  out_flags;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rm     (in_rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          c;
        bit          lat;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_out = 0;
    logic [31:0] cur_res = '0;
    logic [4:0]  cur_flg = '0;
    bit          cur_lat = 1'b0;
    bit          stall_prev = 1'b0;
    logic [36:0] prev_out = '0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (stall_prev)
                check("hold", {out_valid, out_res, out_flags},
                      {1'b1, prev_out});
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("spurious", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("res", out_res, mon_e.res);
                    check("flags", out_flags, mon_e.flg);
                    if (mon_e.lat) check("latency", cyc - mon_e.c, 3);
                    n_out++;
                end
            end
            if (in_valid && in_ready)
                sbq.push_back('{cur_res, cur_flg, cyc, cur_lat});
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_res, out_flags};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [31:0] r,
                        input logic [4:0] f, input bit lat);
        int n = 0;
        in_a = a;
        in_b = b;
        in_rm = rm;
        cur_res = r;
        cur_flg = f;
        cur_lat = lat;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_res", out_res, 0);
        check("rst_flags", out_flags, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1);

        send(32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 5'd0, 1);
        drain();

        send(32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, NV, 1);
        send(32'h7FA00000, 32'h3F800000, 2'b00, 32'h7FC00000, NV, 1);
        send(32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000, 5'd0, 1);
        send(32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, OF | NX, 1);
        send(32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF, OF | NX, 1);
        send(32'hFF000000, 32'h7F000000, 2'b10, 32'hFF800000, OF | NX, 1);
        send(32'h7F000000, 32'h7F000000, 2'b10, 32'h7F7FFFFF, OF | NX, 1);
        send(32'hFF000000, 32'h7F000000, 2'b11, 32'hFF7FFFFF, OF | NX, 1);
        send(32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, NX, 1);
        send(32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800003, NX, 1);
        send(32'h80000000, 32'h3F800000, 2'b00, 32'h80000000, 5'd0, 1);
`ifdef FPMUL_DENORM_EN
        send(32'h00800000, 32'h3F000000, 2'b00, 32'h00400000, 5'd0, 1);
`else
        send(32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, UF | NX, 1);
`endif
        drain();

        n0 = n_out;
        out_ready = 1'b0;
        fork
            begin
                send(32'h3F800000, 32'h40000000, 2'b00, 32'h40000000, 5'd0, 0);
                send(32'h40000000, 32'h40000000, 2'b00, 32'h40800000, 5'd0, 0);
                send(32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 5'd0, 0);
                send(32'hBF800000, 32'h3F800000, 2'b00, 32'hBF800000, 5'd0, 0);
                send(32'h3FC00000, 32'h3FC00000, 2'b00, 32'h40100000, 5'd0, 0);
                send(32'h41200000, 32'h41200000, 2'b00, 32'h42C80000, 5'd0, 0);
            end
            begin
                repeat (5) @(negedge clk);
                check("full_ready", in_ready, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", n_out - n0, 6);

        send(32'h40000000, 32'h40000000, 2'b00, 32'h40800000, 5'd0, 0);
        send(32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 5'd0, 0);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("midrst_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        n0 = n_out;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_stale", n_out - n0, 0);
        check("midrst_idle", out_valid, 0);

        send(32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 5'd0, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
